// File: rtl/drink_pkg.sv
// drink_pkg: state encodings, default parameters and constants shared with the drink-status FSM
package drink_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    VEND      = 3'd1,
    WAIT_DROP = 3'd2,
    CHANGE    = 3'd3,
    ERR       = 3'd4
  } state_t;
  localparam int VEND_CYCLES_DEF   = 8;
  localparam int CHANGE_CYCLES_DEF = 4;
  localparam int DROP_TIMEOUT_DEF  = 32;
  localparam int QDEPTH_DEF        = 4;
  localparam logic [4:0] PRICE     = 5'd15;
  localparam logic [4:0] COIN_5    = 5'd5;
  localparam logic [4:0] COIN_10   = 5'd10;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/drink_req_fifo.sv
// drink_req_fifo: 1-bit synchronous request FIFO; a push into a full FIFO is accepted only alongside a pop
module drink_req_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     din,
  output logic                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] mem;
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign dout    = mem[rp];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/drink_dispense_ctrl.sv
// drink_dispense_ctrl: queues vend/change strobes and sequences motor, drop sensor and coin ejector
module drink_dispense_ctrl
  import drink_pkg::*;
#(
  parameter int VEND_CYCLES   = VEND_CYCLES_DEF,
  parameter int CHANGE_CYCLES = CHANGE_CYCLES_DEF,
  parameter int DROP_TIMEOUT  = DROP_TIMEOUT_DEF,
  parameter int QDEPTH        = QDEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      out_in,
  input  logic                      cout_in,
  input  logic                      drop_ok,
  output logic                      motor_on,
  output logic                      coin_eject,
  output logic                      busy,
  output logic [$clog2(QDEPTH):0]   pending,
  output logic                      ovf,
  output logic                      err_timeout
);
  localparam int CW = $clog2(max3(VEND_CYCLES, CHANGE_CYCLES, DROP_TIMEOUT) + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic chg, chg_n, motor_n, coin_n, err_n, pop, full, empty, fifo_dout;
  drink_req_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (out_in),
    .pop   (pop),
    .din   (cout_in),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (pending)
  );
  assign busy    = (state != IDLE) || !empty;
  assign cnt_inc = cnt + 1'b1;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    chg_n   = chg;
    motor_n = motor_on;
    coin_n  = coin_eject;
    err_n   = err_timeout;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        chg_n   = fifo_dout;
        cnt_n   = '0;
        motor_n = 1'b1;
        state_n = VEND;
      end
      VEND: if (cnt == CW'(VEND_CYCLES - 1)) begin
        motor_n = 1'b0;
        cnt_n   = '0;
        state_n = WAIT_DROP;
      end else cnt_n = cnt_inc;
      // drop_ok has priority over the timeout on the same edge
      WAIT_DROP: if (drop_ok) begin
        coin_n  = chg;
        cnt_n   = '0;
        state_n = chg ? CHANGE : IDLE;
      end else if (cnt_inc == CW'(DROP_TIMEOUT)) begin
        err_n   = 1'b1;
        state_n = ERR;
      end else cnt_n = cnt_inc;
      CHANGE: if (cnt == CW'(CHANGE_CYCLES - 1)) begin
        coin_n  = 1'b0;
        state_n = IDLE;
      end else cnt_n = cnt_inc;
      default: begin
        motor_n = 1'b0;
        coin_n  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      chg         <= 1'b0;
      motor_on    <= 1'b0;
      coin_eject  <= 1'b0;
      err_timeout <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      chg         <= chg_n;
      motor_on    <= motor_n;
      coin_eject  <= coin_n;
      err_timeout <= err_n;
      ovf         <= ovf | (out_in & full & ~pop);
    end
  end
endmodule

// File: tb/tb_drink_dispense_ctrl.sv
// tb_drink_dispense_ctrl: directed checks of queueing, vend/change timing, overflow, timeout and reset
module tb_drink_dispense_ctrl;
  logic clk = 1'b0, reset = 1'b0, out_in = 1'b0, cout_in = 1'b0, drop_ok = 1'b0;
  logic motor_on, coin_eject, busy, ovf, err_timeout;
  logic [2:0] pending;
  int total = 0, bad = 0;
  int mot_cyc = 0, coin_cyc = 0, coin_rises = 0;
  int vq[$];
  logic pm = 1'b0, pc = 1'b0;
  always #5 clk = ~clk;
  drink_dispense_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .out_in      (out_in),
    .cout_in     (cout_in),
    .drop_ok     (drop_ok),
    .motor_on    (motor_on),
    .coin_eject  (coin_eject),
    .busy        (busy),
    .pending     (pending),
    .ovf         (ovf),
    .err_timeout (err_timeout)
  );
  // each vend records how many coin pulses had started before it; the next entry tells its chg bit
  always @(negedge clk) begin
    if (motor_on && !pm) vq.push_back(coin_rises + int'(coin_eject && !pc));
    mot_cyc    <= mot_cyc + int'(motor_on);
    coin_cyc   <= coin_cyc + int'(coin_eject);
    coin_rises <= coin_rises + int'(coin_eject && !pc);
    pm         <= motor_on;
    pc         <= coin_eject;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_motor"}, motor_on, 0);
    chk({tag, "_coin"}, coin_eject, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pending"}, pending, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_err"}, err_timeout, 0);
  endtask
  initial begin
    int m0, c0, base, chg_k;
    logic [5:0] pat;
    #1;
    // 1: reset with random inputs
    reset = 1'b0;
    repeat (3) begin
      out_in  = 1'($urandom);
      cout_in = 1'($urandom);
      drop_ok = 1'($urandom);
      step();
    end
    chk_zero("rst_hold");
    out_in = 1'b0; cout_in = 1'b0; drop_ok = 1'b0; reset = 1'b1;
    step();
    chk_zero("rst_rel");
    // 2: single vend without change
    m0 = mot_cyc; c0 = coin_cyc;
    out_in = 1'b1;
    step();
    out_in = 1'b0;
    chk("t2_e0_motor", motor_on, 0);
    chk("t2_e0_pending", pending, 1);
    step();
    chk("t2_e1_motor", motor_on, 1);
    chk("t2_e1_pending", pending, 0);
    chk("t2_e1_busy", busy, 1);
    step(7);
    chk("t2_e8_motor", motor_on, 1);
    step();
    chk("t2_e9_motor", motor_on, 0);
    step(2);
    drop_ok = 1'b1;
    step();
    drop_ok = 1'b0;
    chk("t2_busy", busy, 0);
    chk("t2_mot_cyc", mot_cyc - m0, 8);
    chk("t2_coin_cyc", coin_cyc - c0, 0);
    // 3: vend with change, then a lone cout_in
    m0 = mot_cyc; c0 = coin_cyc;
    out_in = 1'b1; cout_in = 1'b1;
    step();
    out_in = 1'b0; cout_in = 1'b0; drop_ok = 1'b1;
    step(9);
    chk("t3_e9_motor", motor_on, 0);
    chk("t3_e9_coin", coin_eject, 0);
    step();
    chk("t3_e10_coin", coin_eject, 1);
    step(3);
    chk("t3_e13_coin", coin_eject, 1);
    step();
    chk("t3_e14_coin", coin_eject, 0);
    step(6);
    drop_ok = 1'b0;
    chk("t3_mot_cyc", mot_cyc - m0, 8);
    chk("t3_coin_cyc", coin_cyc - c0, 4);
    chk("t3_busy", busy, 0);
    cout_in = 1'b1;
    step();
    cout_in = 1'b0;
    chk("t3_lone_pending", pending, 0);
    step(3);
    chk("t3_lone_busy", busy, 0);
    chk("t3_lone_mot", mot_cyc - m0, 8);
    // 4: queueing and overflow
    m0 = mot_cyc; c0 = coin_cyc; base = vq.size();
    pat = 6'b101101;
    drop_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      out_in = 1'b1; cout_in = pat[k];
      step();
      out_in = 1'b0; cout_in = 1'b0;
      if (k == 4) begin
        chk("t4_pending_full", pending, 4);
        chk("t4_ovf_before", ovf, 0);
      end
      if (k == 5) begin
        chk("t4_ovf", ovf, 1);
        chk("t4_pending_ovf", pending, 4);
      end
      step();
    end
    for (int i = 0; i < 300 && busy; i++) step();
    drop_ok = 1'b0;
    step();
    chk("t4_idle", busy, 0);
    chk("t4_vends", vq.size() - base, 5);
    chk("t4_mot_cyc", mot_cyc - m0, 40);
    chk("t4_coin_cyc", coin_cyc - c0, 12);
    for (int k = 0; k < 5; k++) begin
      if (base + k < vq.size()) begin
        chg_k = ((base + k + 1 < vq.size()) ? vq[base + k + 1] : coin_rises) - vq[base + k];
        chk($sformatf("t4_chg%0d", k), chg_k, 32'(pat[k]));
      end
    end
    // 5: stuck-drink timeout
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("t5_ovf_clr", ovf, 0);
    out_in = 1'b1;
    step();
    out_in = 1'b0;
    step(40);
    chk("t5_err_before", err_timeout, 0);
    chk("t5_busy", busy, 1);
    step();
    chk("t5_err", err_timeout, 1);
    m0 = mot_cyc;
    out_in = 1'b1;
    step();
    out_in = 1'b0;
    chk("t5_err_pending", pending, 1);
    step(20);
    chk("t5_err_mot", mot_cyc - m0, 0);
    chk("t5_err_pending2", pending, 1);
    chk("t5_err_sticky", err_timeout, 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_zero("t5_rst");
    // 6: reset in the middle of a vend
    out_in = 1'b1;
    step();
    out_in = 1'b0;
    step();
    out_in = 1'b1;
    step();
    out_in = 1'b0;
    step();
    out_in = 1'b1;
    step();
    out_in = 1'b0;
    chk("t6_motor_c4", motor_on, 1);
    chk("t6_pending", pending, 2);
    reset = 1'b0;
    step();
    chk("t6_motor_rst", motor_on, 0);
    chk("t6_pending_rst", pending, 0);
    reset = 1'b1;
    m0 = mot_cyc;
    step(20);
    chk("t6_no_service", mot_cyc - m0, 0);
    chk("t6_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
